// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_pkg
//  Purpose  : Shared types and constants for the keccak byte feeder.
//             Holds the feeder state encoding and the word geometry.
//  Revision : 1.0  initial release
// ============================================================================
package keccak_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        FEED_COLLECT   = 2'd0,
        FEED_SEND      = 2'd1,
        FEED_SEND_LAST = 2'd2,
        FEED_DONE      = 2'd3
    } feed_state_t;

endpackage
`default_nettype wire

// File: rtl/keccak_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_feeder_if
//  Purpose  : Bundles the upstream byte handshake and the padder word
//             interface of the keccak core.
//  Signals  : s_data/s_valid/s_last/s_ready/msg_end  - byte stream side
//             in/in_ready/is_last/byte_num/buffer_full - core word side
//  Modports : master - the feeder; slave - the byte source plus keccak core
//  Revision : 1.0  initial release
// ============================================================================
interface keccak_feeder_if;
    import keccak_pkg::*;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              msg_end;
    logic [WORD_W-1:0] in;
    logic              in_ready;
    logic              is_last;
    logic [1:0]        byte_num;
    logic              buffer_full;

    modport master (
        input  s_data, s_valid, s_last, msg_end, buffer_full,
        output s_ready, in, in_ready, is_last, byte_num
    );

    modport slave (
        output s_data, s_valid, s_last, msg_end, buffer_full,
        input  s_ready, in, in_ready, is_last, byte_num
    );

endinterface
`default_nettype wire

// File: rtl/keccak_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_byte_packer
//  Purpose  : Byte-lane buffer for the feeder. Writes an accepted byte into
//             lane cnt (lane 0 = bits [31:24]) and exposes the word as it
//             will look after this cycle's byte, so the feeder can load a
//             completed word in the same edge. Cleared lanes read as zero,
//             which gives the zero fill of partial words for free. When the
//             feeder runs with a skid word this buffer is the skid register.
//  Ports    : i_wr/i_data  - byte accepted this cycle
//             i_clr        - word handed to the output registers
//             o_full       - four bytes held (only reachable while stalled)
//             o_cnt_nxt    - byte count including this cycle's byte
//             o_word_nxt   - word including this cycle's byte
//  Revision : 1.0  initial release
// ============================================================================
module keccak_byte_packer
    import keccak_pkg::*;
(
    input  wire               clk,
    input  wire               reset_n,
    input  wire               i_wr,
    input  wire  [7:0]        i_data,
    input  wire               i_clr,
    output logic              o_full,
    output logic [2:0]        o_cnt_nxt,
    output logic [WORD_W-1:0] o_word_nxt
);

    logic [WORD_W-1:0] r_buf;
    logic [2:0]        r_cnt;

    always_comb begin
        o_word_nxt = r_buf;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (i_wr && (r_cnt == 3'(b))) begin
                o_word_nxt[WORD_W-1-8*b -: 8] = i_data;
            end
        end
    end

    assign o_cnt_nxt = r_cnt + {2'b00, i_wr};
    assign o_full    = (r_cnt == 3'(BYTES_PER_WORD));

    // A clear wins over a write: the byte of that cycle has already been
    // folded into o_word_nxt and leaves with the word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf <= '0;
            r_cnt <= 3'd0;
        end else if (i_clr) begin
            r_buf <= '0;
            r_cnt <= 3'd0;
        end else if (i_wr) begin
            r_buf <= o_word_nxt;
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keccak_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_feeder
//  Purpose  : Packs an upstream valid/ready byte stream into 32-bit words for
//             the keccak padder, generating is_last/byte_num and the extra
//             terminator word when a message ends on a word boundary.
//             One message per reset; done is sticky until reset.
//  Ports    : clk, reset_n (async, active low)
//             bus          - keccak_feeder_if.master (byte + word handshakes)
//             o_done       - final word accepted by the core
//             o_msg_bytes  - bytes accepted, saturating
//  Options  : KECCAK_FEEDER_SKID_EN - keep accepting bytes into a skid word
//             while a full, non-final word is stalled by buffer_full.
//  Revision : 1.0  initial release
// ============================================================================
module keccak_feeder
    import keccak_pkg::*;
#(
    parameter int LEN_W = 32
)
(
    input  wire               clk,
    input  wire               reset_n,
    keccak_feeder_if.master   bus,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_msg_bytes
);

    feed_state_t       r_state, w_state;
    feed_state_t       r_next,  w_next;     // where SEND goes after transfer
    logic [WORD_W-1:0] r_in,    w_in;
    logic              r_in_ready, w_in_ready;
    logic              r_is_last,  w_is_last;
    logic [1:0]        r_byte_num, w_byte_num;
    logic              r_done,     w_done;
    logic              r_end_pend, w_end_pend;  // end seen while stalled
    logic [LEN_W-1:0]  r_msg_bytes;

    logic              w_s_ready, w_acc, w_end_now, w_end, w_xfer;
    logic              w_slot_free, w_clr, w_full;
    logic [2:0]        w_cnt_nxt;
    logic [WORD_W-1:0] w_word_nxt;

    // reset_n gates s_ready so it reads 0 while reset is held.
`ifdef KECCAK_FEEDER_SKID_EN
    assign w_s_ready = reset_n && !w_full && !r_end_pend &&
                       ((r_state == FEED_COLLECT) ||
                        ((r_state == FEED_SEND) && (r_next == FEED_COLLECT)));
`else
    assign w_s_ready = reset_n && !w_full && (r_state == FEED_COLLECT);
`endif

    assign w_acc     = bus.s_valid && w_s_ready;
    // msg_end with an accepted byte acts as s_last on that byte; with
    // s_last already set it adds nothing.
    assign w_end_now = w_s_ready && (bus.msg_end || (bus.s_valid && bus.s_last));
    assign w_end     = w_end_now || r_end_pend;
    assign w_xfer    = r_in_ready && !bus.buffer_full;

    keccak_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr       (w_acc),
        .i_data     (bus.s_data),
        .i_clr      (w_clr),
        .o_full     (w_full),
        .o_cnt_nxt  (w_cnt_nxt),
        .o_word_nxt (w_word_nxt)
    );

    always_comb begin
        w_state     = r_state;
        w_next      = r_next;
        w_in        = r_in;
        w_in_ready  = r_in_ready;
        w_is_last   = r_is_last;
        w_byte_num  = r_byte_num;
        w_done      = r_done;
        w_end_pend  = r_end_pend;
        w_clr       = 1'b0;
        w_slot_free = 1'b0;

        case (r_state)
            FEED_COLLECT: w_slot_free = 1'b1;
            FEED_SEND: begin
                if (w_xfer) begin
                    w_in_ready = 1'b0;
                    w_is_last  = 1'b0;
                    w_byte_num = 2'd0;
                    case (r_next)
                        FEED_SEND_LAST: begin
                            w_state    = FEED_SEND_LAST;
                            w_in       = '0;
                            w_in_ready = 1'b1;
                            w_is_last  = 1'b1;
                        end
                        FEED_DONE: begin
                            w_state = FEED_DONE;
                            w_done  = 1'b1;
                        end
                        default: begin
                            // Output slot frees up; the skid word (if any)
                            // is evaluated below in this same edge.
                            w_state     = FEED_COLLECT;
                            w_slot_free = 1'b1;
                        end
                    endcase
                end else if (w_end_now) begin
                    w_end_pend = 1'b1;
                end
            end
            FEED_SEND_LAST: begin
                if (w_xfer) begin
                    w_state    = FEED_DONE;
                    w_in_ready = 1'b0;
                    w_is_last  = 1'b0;
                    w_done     = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_slot_free) begin
            w_end_pend = 1'b0;
            if (w_end) begin
                w_clr      = 1'b1;
                w_in_ready = 1'b1;
                if (w_cnt_nxt == 3'd0) begin
                    w_state    = FEED_SEND_LAST;
                    w_in       = '0;
                    w_is_last  = 1'b1;
                    w_byte_num = 2'd0;
                end else if (w_cnt_nxt == 3'(BYTES_PER_WORD)) begin
                    // Full final word still needs the empty terminator.
                    w_state    = FEED_SEND;
                    w_next     = FEED_SEND_LAST;
                    w_in       = w_word_nxt;
                    w_is_last  = 1'b0;
                    w_byte_num = 2'd0;
                end else begin
                    w_state    = FEED_SEND;
                    w_next     = FEED_DONE;
                    w_in       = w_word_nxt;
                    w_is_last  = 1'b1;
                    w_byte_num = w_cnt_nxt[1:0];
                end
            end else if (w_cnt_nxt == 3'(BYTES_PER_WORD)) begin
                w_clr      = 1'b1;
                w_state    = FEED_SEND;
                w_next     = FEED_COLLECT;
                w_in       = w_word_nxt;
                w_in_ready = 1'b1;
                w_is_last  = 1'b0;
                w_byte_num = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= FEED_COLLECT;
            r_next      <= FEED_COLLECT;
            r_in        <= '0;
            r_in_ready  <= 1'b0;
            r_is_last   <= 1'b0;
            r_byte_num  <= 2'd0;
            r_done      <= 1'b0;
            r_end_pend  <= 1'b0;
            r_msg_bytes <= '0;
        end else begin
            r_state    <= w_state;
            r_next     <= w_next;
            r_in       <= w_in;
            r_in_ready <= w_in_ready;
            r_is_last  <= w_is_last;
            r_byte_num <= w_byte_num;
            r_done     <= w_done;
            r_end_pend <= w_end_pend;
            if (w_acc && (r_msg_bytes != '1)) begin
                r_msg_bytes <= r_msg_bytes + 1'b1;
            end
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.in       = r_in;
    assign bus.in_ready = r_in_ready;
    assign bus.is_last  = r_is_last;
    assign bus.byte_num = r_byte_num;
    assign o_done       = r_done;
    assign o_msg_bytes  = r_msg_bytes;

endmodule
`default_nettype wire

// File: tb/tb_keccak_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keccak_feeder
//  Purpose  : Self-checking bench for keccak_feeder. A byte-level model
//             pushes expected words into a scoreboard as bytes are driven;
//             the monitor pops and compares on every word transfer.
//  Options  : KECCAK_FEEDER_SKID_EN selects the skid expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keccak_feeder;

`ifdef KECCAK_FEEDER_SKID_EN
    localparam bit c_skid = 1'b1;
`else
    localparam bit c_skid = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        done;
    logic [31:0] msg_bytes;

    keccak_feeder_if bus ();

    keccak_feeder #(.LEN_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .o_done      (done),
        .o_msg_bytes (msg_bytes)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic        l;
        logic [1:0]  n;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mbuf;
    int          mcnt;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push(input logic [31:0] w, input logic l, input logic [1:0] n);
        exp_t e;
        e.w = w; e.l = l; e.n = n;
        sb.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit last);
        mbuf[31-8*mcnt -: 8] = b;
        mcnt++;
        if (last) begin
            if (mcnt < 4) push(mbuf, 1'b1, 2'(mcnt));
            else begin
                push(mbuf, 1'b0, 2'd0);
                push(32'h0, 1'b1, 2'd0);
            end
            mcnt = 0; mbuf = '0;
        end else if (mcnt == 4) begin
            push(mbuf, 1'b0, 2'd0);
            mcnt = 0; mbuf = '0;
        end
    endtask

    task automatic model_end();
        if (mcnt == 0) push(32'h0, 1'b1, 2'd0);
        else           push(mbuf, 1'b1, 2'(mcnt));
        mcnt = 0; mbuf = '0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.is_last && !bus.in_ready) chk("is_last_wo_ready", 1, 0);
            if (bus.in_ready && !bus.buffer_full) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", bus.in, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word", bus.in, e.w);
                    chk("is_last", bus.is_last, e.l);
                    chk("byte_num", bus.byte_num, e.n);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset_n         = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = 8'h00;
        bus.s_last      = 1'b0;
        bus.msg_end     = 1'b0;
        bus.buffer_full = 1'b0;
        sb.delete();
        mcnt = 0; mbuf = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_in", bus.in, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_is_last", bus.is_last, 0);
        chk("rst_byte_num", bus.byte_num, 0);
        chk("rst_done", done, 0);
        chk("rst_msg_bytes", msg_bytes, 0);
        reset_n = 1'b1;
        #1;
        chk("idle_s_ready", bus.s_ready, 1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input bit last);
        bit ok = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        bus.s_last  = last;
        model_byte(b, last);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin ok = 1; break; end
        end
        if (!ok) chk("byte_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic pulse_end();
        bus.msg_end = 1'b1;
        model_end();
        @(posedge clk);
        #1;
        bus.msg_end = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] exp_bytes);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        chk("done", ok, 1);
        chk("msg_bytes", msg_bytes, exp_bytes);
        chk("s_ready_after_done", bus.s_ready, 0);
        chk("sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] held;

    initial begin
        // 1: "abc" -> single partial final word
        do_reset();
        send_byte(8'h61, 0);
        send_byte(8'h62, 0);
        send_byte(8'h63, 1);
        chk("latency_in_ready", bus.in_ready, 1);
        wait_done(32'd3);

        // 2: eight bytes ending on a word boundary -> terminator word
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_done(32'd8);

        // 3: empty message
        do_reset();
        pulse_end();
        wait_done(32'd0);

        // 4: full word stalled by buffer_full for 10 cycles
        do_reset();
        bus.buffer_full = 1'b1;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        held = bus.in;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_in", bus.in, 32'h11223344);
            chk("stall_in_ready", bus.in_ready, 1);
            chk("stall_s_ready", bus.s_ready, c_skid);
        end
        @(posedge clk);
        #1;
        bus.buffer_full = 1'b0;
        @(posedge clk);
        #1;
        chk("xfer_first_free", bus.in_ready, 0);
        pulse_end();
        wait_done(32'd4);

        // 5: async reset mid-message, then fresh single byte
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_msg_bytes", msg_bytes, 0);
        chk("async_s_ready", bus.s_ready, 0);
        chk("async_in_ready", bus.in_ready, 0);
        sb.delete();
        mcnt = 0; mbuf = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_byte(8'hAA, 1);
        wait_done(32'd1);

        // 6: msg_end after a partial word
        do_reset();
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        pulse_end();
        wait_done(32'd2);

`ifdef KECCAK_FEEDER_SKID_EN
        // 7: skid word fills while stalled, 9th byte held off
        do_reset();
        bus.buffer_full = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i), 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h29;
        bus.s_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("skid_hold", bus.s_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.buffer_full = 1'b0;
        send_byte(8'h29, 1);
        wait_done(32'd9);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
